// File: rtl/s2l_stream_capture_if.sv
// Stream-side and register-file-side handshake bundle for s2l_stream_capture.
// slave is the capture block's view; master is the driver/register-file view.
interface s2l_stream_capture_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32
);
  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXIS_TDATA;
  logic                          S_AXIS_TVALID;
  logic                          S_AXIS_TLAST;
  logic                          S_AXIS_TREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0] incoming_data;
  logic                          tvalid;
  logic                          tlast;
  logic [1:0]                    wr_ptr;
  logic                          ready;

  modport slave (
    input  S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, ready,
    output S_AXIS_TREADY, incoming_data, tvalid, tlast, wr_ptr
  );

  modport master (
    output S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, ready,
    input  S_AXIS_TREADY, incoming_data, tvalid, tlast, wr_ptr
  );
endinterface

// File: rtl/s2l_stream_capture.sv
// Captures up to four words per stream frame into a register-file stage and holds off
// the stream until software acknowledges. `S2L_CAPTURE_OVF_CNT_EN enables ovf_count.
module s2l_stream_capture #(
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  s2l_stream_capture_if.slave           bus,
  output logic [C_S_AXI_DATA_WIDTH-1:0] word_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] frame_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ovf_count
);

  localparam logic [1:0] ST_RECV = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [C_S_AXI_DATA_WIDTH-1:0] ONE = 1;

  logic [1:0]                    r_state;
  logic [2:0]                    r_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_replay;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_data_p1;
  logic [1:0]                    r_ptr_p1;
  logic                          r_vld_p1;
  logic                          r_last_p1;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_word_cnt;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_frame_cnt;

  logic w_tready;
  logic w_accept;
  logic w_direct;
  logic w_replay_out;

  assign w_tready     = (r_state == ST_RECV) && !bus.ready && !S_AXI_ARESET;
  assign w_accept     = bus.S_AXIS_TVALID && w_tready;
  assign w_direct     = w_accept && (r_idx != 3'd4);
  // Once saturated, the final beat re-emits the fourth word so software still sees tlast.
  assign w_replay_out = w_accept && (r_idx == 3'd4) && bus.S_AXIS_TLAST;

  // Stage p0 -> p1: accepted beat becomes a register-file write strobe
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      r_ptr_p1  <= 2'd0;
      r_data_p1 <= '0;
      r_replay  <= '0;
    end else begin
      r_vld_p1  <= w_direct || w_replay_out;
      r_last_p1 <= (w_direct && bus.S_AXIS_TLAST) || w_replay_out;
      if (w_direct) begin
        r_ptr_p1  <= r_idx[1:0];
        r_data_p1 <= bus.S_AXIS_TDATA;
        if (r_idx == 3'd3) r_replay <= bus.S_AXIS_TDATA;
      end else if (w_replay_out) begin
        r_ptr_p1  <= 2'd3;
        r_data_p1 <= r_replay;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state     <= ST_RECV;
      r_idx       <= 3'd0;
      r_word_cnt  <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_word_cnt <= r_word_cnt + ONE;
        if (bus.S_AXIS_TLAST) begin
          r_frame_cnt <= r_frame_cnt + ONE;
          r_idx       <= 3'd0;
        end else if (r_idx != 3'd4) begin
          r_idx <= r_idx + 3'd1;
        end
      end
      case (r_state)
        ST_RECV: if (w_accept && bus.S_AXIS_TLAST) r_state <= ST_WAIT;
        // One dead cycle lets the register file raise ready before it is looked at.
        ST_WAIT: r_state <= ST_HOLD;
        ST_HOLD: if (!bus.ready) r_state <= ST_RECV;
        default: r_state <= ST_RECV;
      endcase
    end
  end

`ifdef S2L_CAPTURE_OVF_CNT_EN
  logic [C_S_AXI_DATA_WIDTH-1:0] r_ovf_cnt;

  function automatic logic [C_S_AXI_DATA_WIDTH-1:0] sat_inc(
    input logic [C_S_AXI_DATA_WIDTH-1:0] v
  );
    return (&v) ? v : v + ONE;
  endfunction

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) r_ovf_cnt <= '0;
    else if (w_replay_out) r_ovf_cnt <= sat_inc(r_ovf_cnt);
  end

  assign ovf_count = r_ovf_cnt;
`else
  assign ovf_count = '0;
`endif

  assign bus.S_AXIS_TREADY = w_tready;
  assign bus.incoming_data = r_data_p1;
  assign bus.tvalid        = r_vld_p1;
  assign bus.tlast         = r_last_p1;
  assign bus.wr_ptr        = r_ptr_p1;
  assign word_count        = r_word_cnt;
  assign frame_count       = r_frame_cnt;

endmodule

// File: tb/tb_s2l_stream_capture.sv
// Bench for s2l_stream_capture: beat table with expected strobes, scoreboard queue,
// plus hand-written ready/reset sequences.
module tb_s2l_stream_capture;

  logic        clk;
  logic        rst;
  logic [31:0] word_count;
  logic [31:0] frame_count;
  logic [31:0] ovf_count;

  s2l_stream_capture_if #(.C_S_AXI_DATA_WIDTH(32)) bus ();

  s2l_stream_capture #(.C_S_AXI_DATA_WIDTH(32)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .bus          (bus.slave),
    .word_count   (word_count),
    .frame_count  (frame_count),
    .ovf_count    (ovf_count)
  );

`ifdef S2L_CAPTURE_OVF_CNT_EN
  localparam logic [31:0] OVF_ONE = 32'd1;
`else
  localparam logic [31:0] OVF_ONE = 32'd0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        exp_vld;
    logic [31:0] exp_data;
    logic [1:0]  exp_ptr;
    logic        exp_last;
  } vec_t;

  vec_t tbl [15];
  vec_t q [$];
  int   n_chk  = 0;
  int   n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Advance to the next falling edge and compare the strobe the DUT presents.
  task automatic step();
    vec_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      check("strobe_vld", {31'd0, bus.tvalid}, 32'd1);
      check("strobe_data", bus.incoming_data, e.exp_data);
      check("strobe_ptr", {30'd0, bus.wr_ptr}, {30'd0, e.exp_ptr});
      check("strobe_last", {31'd0, bus.tlast}, {31'd0, e.exp_last});
    end else begin
      check("idle_vld", {31'd0, bus.tvalid}, 32'd0);
      check("idle_last", {31'd0, bus.tlast}, 32'd0);
    end
  endtask

  task automatic send(input int i);
    int w;
    w = 0;
    bus.S_AXIS_TDATA  = tbl[i].data;
    bus.S_AXIS_TLAST  = tbl[i].last;
    bus.S_AXIS_TVALID = 1'b1;
    #1;
    while (!bus.S_AXIS_TREADY && w < 50) begin
      step();
      w++;
    end
    if (!bus.S_AXIS_TREADY) begin
      check("tready_timeout", 32'd0, 32'd1);
    end else begin
      if (tbl[i].exp_vld) q.push_back(tbl[i]);
      step();
    end
    bus.S_AXIS_TVALID = 1'b0;
    bus.S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic check_counts(input string tag, input logic [31:0] w,
                              input logic [31:0] f, input logic [31:0] o);
    check({tag, "_word_count"}, word_count, w);
    check({tag, "_frame_count"}, frame_count, f);
    check({tag, "_ovf_count"}, ovf_count, o);
  endtask

  initial begin
    tbl[0]  = '{32'hA000_0000, 1'b0, 1'b1, 32'hA000_0000, 2'd0, 1'b0};
    tbl[1]  = '{32'hA111_1111, 1'b0, 1'b1, 32'hA111_1111, 2'd1, 1'b0};
    tbl[2]  = '{32'hA222_2222, 1'b0, 1'b1, 32'hA222_2222, 2'd2, 1'b0};
    tbl[3]  = '{32'hA333_3333, 1'b1, 1'b1, 32'hA333_3333, 2'd3, 1'b1};
    tbl[4]  = '{32'hB000_0000, 1'b0, 1'b1, 32'hB000_0000, 2'd0, 1'b0};
    tbl[5]  = '{32'hB111_1111, 1'b0, 1'b1, 32'hB111_1111, 2'd1, 1'b0};
    tbl[6]  = '{32'hB222_2222, 1'b0, 1'b1, 32'hB222_2222, 2'd2, 1'b0};
    tbl[7]  = '{32'hB333_3333, 1'b0, 1'b1, 32'hB333_3333, 2'd3, 1'b0};
    tbl[8]  = '{32'hB444_4444, 1'b0, 1'b0, 32'h0000_0000, 2'd0, 1'b0};
    tbl[9]  = '{32'hB555_5555, 1'b1, 1'b1, 32'hB333_3333, 2'd3, 1'b1};
    tbl[10] = '{32'hC000_0000, 1'b1, 1'b1, 32'hC000_0000, 2'd0, 1'b1};
    tbl[11] = '{32'hD000_0000, 1'b0, 1'b1, 32'hD000_0000, 2'd0, 1'b0};
    tbl[12] = '{32'hD111_1111, 1'b0, 1'b1, 32'hD111_1111, 2'd1, 1'b0};
    tbl[13] = '{32'hE000_0000, 1'b0, 1'b1, 32'hE000_0000, 2'd0, 1'b0};
    tbl[14] = '{32'hE111_1111, 1'b1, 1'b1, 32'hE111_1111, 2'd1, 1'b1};

    rst = 1'b1;
    bus.S_AXIS_TDATA  = 32'h0;
    bus.S_AXIS_TVALID = 1'b0;
    bus.S_AXIS_TLAST  = 1'b0;
    bus.ready         = 1'b0;

    // Reset state
    step();
    step();
    check("rst_tready", {31'd0, bus.S_AXIS_TREADY}, 32'd0);
    check("rst_data", bus.incoming_data, 32'd0);
    check("rst_ptr", {30'd0, bus.wr_ptr}, 32'd0);
    check_counts("rst", 32'd0, 32'd0, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_tready", {31'd0, bus.S_AXIS_TREADY}, 32'd1);

    // Frame A: four beats, then software holds ready for 10 cycles
    for (int i = 0; i < 4; i++) send(i);
    check_counts("frameA", 32'd4, 32'd1, 32'd0);
    bus.ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("hold_tready", {31'd0, bus.S_AXIS_TREADY}, 32'd0);
    end
    bus.ready = 1'b0;
    #1;
    check("ready_fall_tready", {31'd0, bus.S_AXIS_TREADY}, 32'd0);
    step();
    check("resume_tready", {31'd0, bus.S_AXIS_TREADY}, 32'd1);

    // Frame B: six beats, overflow replay; ready never rises (collision)
    for (int i = 4; i < 10; i++) send(i);
    check("coll_wait_tready", {31'd0, bus.S_AXIS_TREADY}, 32'd0);
    step();
    check("coll_hold_tready", {31'd0, bus.S_AXIS_TREADY}, 32'd0);
    step();
    check("coll_recv_tready", {31'd0, bus.S_AXIS_TREADY}, 32'd1);
    check_counts("frameB", 32'd10, 32'd2, OVF_ONE);

    // Frame C: one-beat frame
    send(10);
    step();
    step();
    check_counts("frameC", 32'd11, 32'd3, OVF_ONE);

    // Frame D aborted by reset after two beats, with a pending TLAST beat on the bus
    send(11);
    send(12);
    bus.S_AXIS_TDATA  = 32'hDEAD_BEEF;
    bus.S_AXIS_TLAST  = 1'b1;
    bus.S_AXIS_TVALID = 1'b1;
    rst = 1'b1;
    step();
    step();
    bus.S_AXIS_TVALID = 1'b0;
    bus.S_AXIS_TLAST  = 1'b0;
    rst = 1'b0;
    check_counts("midrst", 32'd0, 32'd0, 32'd0);
    step();

    // Frame E restarts at wr_ptr 0
    send(13);
    send(14);
    check_counts("frameE", 32'd2, 32'd1, 32'd0);
    step();
    step();
    step();
    check("sb_drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
